lcd_stream_driver: RTL
======================

# lcd_stream_driver

Parametrised LCD timing generator and pixel fetch engine; successor to the fixed 480x272 LCD driver. It generates HS/VS/DE for any panel geometry and reads pixels from the upstream async FIFO read port in the pixel clock domain. It issues frame-sync and line-ahead request strobes to the FIFO controller, and substitutes a fill colour on FIFO underflow while counting the events. It is instantiated inside the LCD top level, between the AXI-stream FIFO and the panel pins.

## Interface
- H_ACTIVE, 480, active pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, HS pulse width (clocks)
- H_BP, 2, horizontal back porch (clocks)
- V_ACTIVE, 272, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, VS pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- DATA_W, 24, pixel width
- HS_POL, 0, HS active level
- VS_POL, 0, VS active level
- CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FILL_COLOR, 24'h000000, pixel output on underflow

Ports:
- clk  in  1  pixel clock (lcd_pixel_clk domain); one clock; reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run request
- test_mode  in  1  colour-bar select (honoured only with LCD_TEST_PATTERN_EN)
- pix_valid  in  1  FIFO not empty
- pix_data  in  DATA_W  FIFO dout, valid 1 clk after pix_rd_en
- pix_rd_en  out  1  FIFO read enable
- lcd_request  out  1  line-ahead data request to FIFO controller
- lcd_framesync  out  1  one-clk frame-start pulse
- ufl_clear  in  1  clears underflow counter and flag
- ufl_flag  out  1  sticky underflow
- ufl_cnt  out  16  saturating underflow count
- lcd_dclk  out  1  = ~clk
- lcd_hs, lcd_vs, lcd_en  out  1  panel sync and data enable
- lcd_rgb  out  DATA_W  panel data
- lcd_xpos, lcd_ypos  out  CNT_W  active coordinates of the pixel on lcd_rgb (0 outside active area)

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. Line order: sync, back porch, active, front porch.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments on each h wrap, 0..V_TOTAL-1, and wraps.
- de0 = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- FSM IDLE -> RUN -> STOPPING -> IDLE.
  - IDLE: counters held 0, outputs at reset values. Goes to RUN when enable=1.
  - RUN: counters free-run. Goes to STOPPING when enable=0.
  - STOPPING: counters keep running to the end of the frame. On the last clock of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) the FSM goes to RUN if enable=1, otherwise to IDLE.
- lcd_framesync is 1 in RUN/STOPPING when h_cnt=0 and v_cnt=0.
- lcd_request is 1 in RUN/STOPPING for v_cnt in [V_SYNC+V_BP-1, V_SYNC+V_BP+V_ACTIVE-1), i.e. one line before the first active line through the second-to-last active line.
- pix_rd_en = de0 & pix_valid & ~pattern_active (combinational from the counter registers).
- Underflow: de0=1 and pix_valid=0. That pixel outputs FILL_COLOR, ufl_flag is set, and ufl_cnt increments, saturating at 16'hFFFF.
- ufl_clear has priority over an increment in the same clock.
- Reset values:
  - hs = ~HS_POL, vs = ~VS_POL
  - en, rgb, xpos, ypos, pix_rd_en, lcd_request, lcd_framesync, ufl_flag, ufl_cnt = 0
  - FSM in IDLE
- Reset mid-frame returns everything to the reset values on the next edge. The FIFO is not touched; the controller flushes it on the next framesync.

## Timing
- Stage 0: counters, de0, pix_rd_en, lcd_request, lcd_framesync.
- Stage 1: FIFO data valid; de/hs/vs/underflow flag delayed by one register.
- Stage 2: registered outputs lcd_hs, lcd_vs, lcd_en, lcd_rgb, lcd_xpos, lcd_ypos.
- Counter-to-pin latency is 2 clocks, identical for sync, DE and data, so alignment is exact.
- lcd_rgb = 0 whenever lcd_en = 0.
- ufl_cnt/ufl_flag update 1 clock after the underflowing stage-0 cycle.

## Configuration
- LCD_TEST_PATTERN_EN
- Defined: when test_mode=1, pattern_active=1. Stage 2 outputs 8 vertical colour bars of width H_ACTIVE/8 in the order white, yellow, cyan, green, magenta, red, blue, black; the last bar absorbs the remainder. pix_rd_en is held 0, no underflow is counted, and sync timing is unchanged.
- Undefined: test_mode is ignored, pattern_active=0, and no bar logic is synthesised.

## Test plan
Small geometry for all tests: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1; H_TOTAL=14, V_TOTAL=7.
- Reset/idle: rst_n=0 for 3 clks, then enable=0 -> hs=1, vs=1, en=0, rgb=0, pix_rd_en=0 for 200 clks.
- Normal frame: enable=1, pix_valid=1, data = incrementing counter -> pix_rd_en is high for 8 clks per line at h_cnt 4..11 on v_cnt 2..5, i.e. 32 reads per frame. lcd_en follows 2 clks later, lcd_rgb shows the values in order, and xpos runs 0..7.
- Strobes: lcd_framesync is high exactly once every 98 clks. lcd_request is high for v_cnt 1..4, i.e. 56 clks per frame.
- Underflow: pix_valid=0 for 3 active pixels -> those 3 pixels output FILL_COLOR, ufl_cnt=3, ufl_flag=1. Then pulse ufl_clear -> ufl_cnt=0, ufl_flag=0.
- Graceful stop: drop enable at v_cnt=3 -> the frame completes to clock 97, then the FSM is in IDLE with outputs at reset values. Re-assert enable -> framesync on the next clk.
- Test pattern (macro defined): test_mode=1 -> pix_rd_en=0 throughout, and lcd_rgb per active line is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.

Source files
------------

// File: rtl/lcd_stream_driver.sv
// lcd_stream_driver: LCD timing generator and pixel fetch engine for any panel geometry.
// Latency: counters to panel pins take 2 clocks, the same for HS/VS, DE and pixel data.
// Backpressure: none; an empty FIFO during active video shows FILL_COLOR and is counted.
// Build option: define LCD_TEST_PATTERN_EN to add the 8-bar colour test pattern (test_mode).
module lcd_stream_driver #(
  parameter int                H_ACTIVE   = 480,
  parameter int                H_FP       = 2,
  parameter int                H_SYNC     = 41,
  parameter int                H_BP       = 2,
  parameter int                V_ACTIVE   = 272,
  parameter int                V_FP       = 2,
  parameter int                V_SYNC     = 10,
  parameter int                V_BP       = 2,
  parameter int                DATA_W     = 24,
  parameter bit                HS_POL     = 1'b0,
  parameter bit                VS_POL     = 1'b0,
  parameter int                CNT_W      = 11,
  parameter logic [DATA_W-1:0] FILL_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              test_mode,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_rd_en,
  output logic              lcd_request,
  output logic              lcd_framesync,
  input  logic              ufl_clear,
  output logic              ufl_flag,
  output logic [15:0]       ufl_cnt,
  output logic              lcd_dclk,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_en,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic [CNT_W-1:0]  lcd_xpos,
  output logic [CNT_W-1:0]  lcd_ypos
);

  // Line/frame geometry: sync, back porch, active, front porch
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  // The request window leads the active window by one line so the
  // controller can prefetch the next line while the current one is shown.
  localparam logic [CNT_W-1:0] V_REQ_BEG  = CNT_W'(V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] V_REQ_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   running;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             frame_last;

  // Stage 0 (combinational from the counter registers)
  logic             h_act;
  logic             v_act;
  logic             de0;
  logic             hs0;
  logic             vs0;
  logic             ufl0;
  logic             pattern_active;
  logic [CNT_W-1:0] x0;
  logic [CNT_W-1:0] y0;

  // Stage 1 (aligned with FIFO read data)
  logic             de1;
  logic             hs1;
  logic             vs1;
  logic             ufl1;
  logic [CNT_W-1:0] x1;
  logic [CNT_W-1:0] y1;

  // Pixel chosen for stage 2
  logic [DATA_W-1:0] pix_sel;

  assign lcd_dclk = ~clk;

  assign h_last     = (h_cnt == H_LAST);
  assign frame_last = h_last && (v_cnt == V_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a stop request only takes effect at the end of a frame
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (frame_last) state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: counters and strobes are live in RUN and STOPPING
  always_comb begin
    running = 1'b0;
    case (state)
      ST_RUN, ST_STOPPING: running = 1'b1;
      default:             running = 1'b0;
    endcase
  end

  // Horizontal/vertical counters; held at zero while idle
  always_ff @(posedge clk) begin
    if (!rst_n || !running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  assign pattern_active = test_mode;
`else
  // test_mode has no effect in this build
  assign pattern_active = test_mode & 1'b0;
`endif

  assign h_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign de0   = running && h_act && v_act;

  assign hs0 = (running && (h_cnt < H_SYNC_END)) ? HS_POL : ~HS_POL;
  assign vs0 = (running && (v_cnt < V_SYNC_END)) ? VS_POL : ~VS_POL;

  assign x0 = de0 ? (h_cnt - H_ACT_BEG) : '0;
  assign y0 = de0 ? (v_cnt - V_ACT_BEG) : '0;

  assign pix_rd_en     = de0 && pix_valid && !pattern_active;
  assign ufl0          = de0 && !pix_valid && !pattern_active;
  assign lcd_framesync = running && (h_cnt == '0) && (v_cnt == '0);
  assign lcd_request   = running && (v_cnt >= V_REQ_BEG) && (v_cnt < V_REQ_END);

  // Stage 1: delay control by one clock to meet the FIFO read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de1  <= 1'b0;
      hs1  <= ~HS_POL;
      vs1  <= ~VS_POL;
      ufl1 <= 1'b0;
      x1   <= '0;
      y1   <= '0;
    end else begin
      de1  <= de0;
      hs1  <= hs0;
      vs1  <= vs0;
      ufl1 <= ufl0;
      x1   <= x0;
      y1   <= y0;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  // Eight equal bars; integer division leaves the remainder to the last bar
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam int CH_W  = DATA_W / 3;

  logic [CNT_W-1:0]  bar_q;
  logic [2:0]        bar0;
  logic [2:0]        bar1;
  logic              pat1;
  logic [DATA_W-1:0] bar_color;

  assign bar_q = x0 / CNT_W'(BAR_W);
  assign bar0  = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
  // R = ~idx[1], G = ~idx[2], B = ~idx[0].
  assign bar_color = DATA_W'({{CH_W{~bar1[1]}}, {CH_W{~bar1[2]}}, {CH_W{~bar1[0]}}});

  // Stage 1 companion: carry pattern select and bar index alongside DE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat1 <= 1'b0;
      bar1 <= 3'd0;
    end else begin
      pat1 <= pattern_active;
      bar1 <= bar0;
    end
  end
`endif

  // Pixel source: FIFO data, fill colour on underflow, or the test bars
  always_comb begin
    pix_sel = ufl1 ? FILL_COLOR : pix_data;
`ifdef LCD_TEST_PATTERN_EN
    if (pat1) pix_sel = bar_color;
`endif
  end

  // Stage 2: registered panel outputs; data and coordinates blanked outside DE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcd_hs   <= ~HS_POL;
      lcd_vs   <= ~VS_POL;
      lcd_en   <= 1'b0;
      lcd_rgb  <= '0;
      lcd_xpos <= '0;
      lcd_ypos <= '0;
    end else begin
      lcd_hs   <= hs1;
      lcd_vs   <= vs1;
      lcd_en   <= de1;
      lcd_rgb  <= de1 ? pix_sel : '0;
      lcd_xpos <= de1 ? x1 : '0;
      lcd_ypos <= de1 ? y1 : '0;
    end
  end

  // Underflow bookkeeping: clear wins over a same-cycle increment; count saturates
  always_ff @(posedge clk) begin
    if (!rst_n || ufl_clear) begin
      ufl_flag <= 1'b0;
      ufl_cnt  <= '0;
    end else if (ufl0) begin
      ufl_flag <= 1'b1;
      if (ufl_cnt != 16'hFFFF) ufl_cnt <= ufl_cnt + 16'd1;
    end
  end

endmodule
